wb_block_downsizer: RTL and testbench

Wishbone responder that serves block-wide (default 128-bit) requests from the cache's memory port by issuing a sequence of narrow (default 32-bit) Wishbone beats on a downstream primary bus. It sits between the cache's memory-side `wishbone_if` and a narrow memory or peripheral. It assembles read beats into one block and splits write blocks into beats. It is a secondary on the wide bus and a primary on the narrow bus.

---
 rtl/wb_block_downsizer.sv | 185 ++++++++++++++++++
 tb/tb_wb_block_downsizer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_block_downsizer.sv
// rtl/wb_block_downsizer.sv - serves wide Wishbone block requests as a sequence of narrow beats
module wb_block_downsizer #(
    parameter int WIDE_SIZE   = 128,
    parameter int NARROW_SIZE = 32,
    parameter int ADDR_SIZE   = 15,
    parameter int BYTE_SIZE   = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    // wide secondary side
    input  logic                             s_cyc_i,
    input  logic                             s_stb_i,
    input  logic                             s_we_i,
    input  logic [WIDE_SIZE/BYTE_SIZE-1:0]   s_sel_i,
    input  logic [ADDR_SIZE-1:0]             s_addr_i,
    input  logic [WIDE_SIZE-1:0]             s_dat_i,
    output logic                             s_ack_o,
    output logic [WIDE_SIZE-1:0]             s_dat_o,
    // narrow primary side
    output logic                             p_cyc_o,
    output logic                             p_stb_o,
    output logic                             p_we_o,
    output logic [NARROW_SIZE/BYTE_SIZE-1:0] p_sel_o,
    output logic [ADDR_SIZE-1:0]             p_addr_o,
    output logic [NARROW_SIZE-1:0]           p_dat_o,
    input  logic                             p_ack_i,
    input  logic [NARROW_SIZE-1:0]           p_dat_i
);

    localparam int BEATS        = WIDE_SIZE / NARROW_SIZE;
    localparam int NB           = NARROW_SIZE / BYTE_SIZE;
    localparam int WSEL         = WIDE_SIZE / BYTE_SIZE;
    localparam int BW           = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WIDE_LSB     = $clog2(WIDE_SIZE / 8);
    localparam int NARROW_BYTES = NARROW_SIZE / 8;

    typedef enum logic [1:0] {IDLE, BEAT, GAP, ACK} state_t;

    state_t                 state_q, state_d;
    logic [BW-1:0]          b_q, b_d;
    logic [ADDR_SIZE-1:0]   base_q, base_d;
    logic                   we_q, we_d;
    logic [WSEL-1:0]        sel_q, sel_d;
    logic [WIDE_SIZE-1:0]   wdat_q, wdat_d;
    logic [WIDE_SIZE-1:0]   rdbuf_q, rdbuf_d;
    logic                   s_ack_q, s_ack_d;
    logic [WIDE_SIZE-1:0]   s_dat_q, s_dat_d;
    logic                   p_cyc_q, p_cyc_d;
    logic                   p_stb_q, p_stb_d;
    logic                   p_we_q, p_we_d;
    logic [NB-1:0]          p_sel_q, p_sel_d;
    logic [ADDR_SIZE-1:0]   p_addr_q, p_addr_d;
    logic [NARROW_SIZE-1:0] p_dat_q, p_dat_d;

    logic [ADDR_SIZE-1:0]   aligned_addr;
    logic                   unused_addr_bits;

    // The block is always fetched from its natural alignment; low offset bits are ignored.
    assign aligned_addr     = {s_addr_i[ADDR_SIZE-1:WIDE_LSB], WIDE_LSB'(0)};
    assign unused_addr_bits = ^s_addr_i[WIDE_LSB-1:0];

    always_comb begin
        state_d  = state_q;
        b_d      = b_q;
        base_d   = base_q;
        we_d     = we_q;
        sel_d    = sel_q;
        wdat_d   = wdat_q;
        rdbuf_d  = rdbuf_q;
        s_ack_d  = 1'b0;
        s_dat_d  = s_dat_q;
        p_cyc_d  = 1'b0;
        p_stb_d  = 1'b0;
        p_we_d   = p_we_q;
        p_sel_d  = p_sel_q;
        p_addr_d = p_addr_q;
        p_dat_d  = p_dat_q;

        case (state_q)
            IDLE: begin
                if (s_cyc_i && s_stb_i) begin
                    state_d  = BEAT;
                    b_d      = '0;
                    base_d   = aligned_addr;
                    we_d     = s_we_i;
                    sel_d    = s_sel_i;
                    wdat_d   = s_dat_i;
                    rdbuf_d  = '0;
                    p_cyc_d  = 1'b1;
                    p_stb_d  = 1'b1;
                    p_we_d   = s_we_i;
                    p_addr_d = aligned_addr;
                    p_sel_d  = s_sel_i[NB-1:0];
                    p_dat_d  = s_dat_i[NARROW_SIZE-1:0];
                end
            end
            BEAT: begin
                if (!s_cyc_i) begin
                    state_d = IDLE;
                end else if (p_ack_i) begin
                    if (!we_q) begin
                        rdbuf_d[b_q*NARROW_SIZE +: NARROW_SIZE] = p_dat_i;
                    end
                    if (b_q == BW'(BEATS - 1)) begin
                        state_d = ACK;
                        s_ack_d = 1'b1;
                        s_dat_d = we_q ? wdat_q : rdbuf_d;
                    end else begin
                        // Next beat's lanes are loaded now so they are settled before stb rises.
                        state_d  = GAP;
                        b_d      = b_q + 1'b1;
                        p_cyc_d  = 1'b1;
                        p_addr_d = base_q + ADDR_SIZE'(b_d) * ADDR_SIZE'(NARROW_BYTES);
                        p_sel_d  = sel_q[b_d*NB +: NB];
                        p_dat_d  = wdat_q[b_d*NARROW_SIZE +: NARROW_SIZE];
                    end
                end else begin
                    p_cyc_d = 1'b1;
                    p_stb_d = 1'b1;
                end
            end
            GAP: begin
                if (!s_cyc_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = BEAT;
                    p_cyc_d = 1'b1;
                    p_stb_d = 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            b_q      <= '0;
            base_q   <= '0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            wdat_q   <= '0;
            rdbuf_q  <= '0;
            s_ack_q  <= 1'b0;
            s_dat_q  <= '0;
            p_cyc_q  <= 1'b0;
            p_stb_q  <= 1'b0;
            p_we_q   <= 1'b0;
            p_sel_q  <= '0;
            p_addr_q <= '0;
            p_dat_q  <= '0;
        end else begin
            state_q  <= state_d;
            b_q      <= b_d;
            base_q   <= base_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            wdat_q   <= wdat_d;
            rdbuf_q  <= rdbuf_d;
            s_ack_q  <= s_ack_d;
            s_dat_q  <= s_dat_d;
            p_cyc_q  <= p_cyc_d;
            p_stb_q  <= p_stb_d;
            p_we_q   <= p_we_d;
            p_sel_q  <= p_sel_d;
            p_addr_q <= p_addr_d;
            p_dat_q  <= p_dat_d;
        end
    end

    assign s_ack_o  = s_ack_q;
    assign s_dat_o  = s_dat_q;
    assign p_cyc_o  = p_cyc_q;
    assign p_stb_o  = p_stb_q;
    assign p_we_o   = p_we_q;
    assign p_sel_o  = p_sel_q;
    assign p_addr_o = p_addr_q;
    assign p_dat_o  = p_dat_q;

endmodule

// File: tb/tb_wb_block_downsizer.sv
// tb/tb_wb_block_downsizer.sv - directed bench for wb_block_downsizer against a narrow memory model
module tb_wb_block_downsizer;

    logic         clock = 1'b0;
    logic         reset;
    logic         s_cyc, s_stb, s_we;
    logic [15:0]  s_sel;
    logic [14:0]  s_addr;
    logic [127:0] s_wdat;
    logic         s_ack_o;
    logic [127:0] s_dat_o;
    logic         p_cyc_o, p_stb_o, p_we_o;
    logic [3:0]   p_sel_o;
    logic [14:0]  p_addr_o;
    logic [31:0]  p_dat_o;
    logic         p_ack;
    logic [31:0]  p_rdat;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    wb_block_downsizer dut (
        .clock    (clock),
        .reset    (reset),
        .s_cyc_i  (s_cyc),
        .s_stb_i  (s_stb),
        .s_we_i   (s_we),
        .s_sel_i  (s_sel),
        .s_addr_i (s_addr),
        .s_dat_i  (s_wdat),
        .s_ack_o  (s_ack_o),
        .s_dat_o  (s_dat_o),
        .p_cyc_o  (p_cyc_o),
        .p_stb_o  (p_stb_o),
        .p_we_o   (p_we_o),
        .p_sel_o  (p_sel_o),
        .p_addr_o (p_addr_o),
        .p_dat_o  (p_dat_o),
        .p_ack_i  (p_ack),
        .p_dat_i  (p_rdat)
    );

    // Narrow memory: acks in the n_lat-th cycle of stb, logs every acked beat.
    int          n_lat = 6;
    logic        init_mem;
    int          cnt;
    logic [31:0] mem [0:8191];
    int          log_n;
    logic [14:0] log_addr [0:63];
    logic [3:0]  log_sel  [0:63];
    logic        log_we   [0:63];
    logic [31:0] log_dat  [0:63];

    assign p_ack  = p_cyc_o && p_stb_o && (cnt == n_lat - 1);
    assign p_rdat = mem[p_addr_o[14:2]];

    always @(posedge clock) begin
        if (init_mem) begin
            cnt      <= 0;
            log_n    <= 0;
            mem[4]   <= 32'h11111111;
            mem[5]   <= 32'h22222222;
            mem[6]   <= 32'h33333333;
            mem[7]   <= 32'h44444444;
            mem[16]  <= 32'h55555555;
            mem[17]  <= 32'h55555555;
            mem[18]  <= 32'h55555555;
            mem[19]  <= 32'h55555555;
        end else begin
            if (p_stb_o && !p_ack) cnt <= cnt + 1;
            else                   cnt <= 0;
            if (p_ack) begin
                log_addr[log_n] <= p_addr_o;
                log_sel[log_n]  <= p_sel_o;
                log_we[log_n]   <= p_we_o;
                log_dat[log_n]  <= p_dat_o;
                log_n           <= log_n + 1;
                if (p_we_o) begin
                    for (int i = 0; i < 4; i++)
                        if (p_sel_o[i]) mem[p_addr_o[14:2]][i*8 +: 8] <= p_dat_o[i*8 +: 8];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one wide request starting in the current cycle (cycle 0) and returns the ack cycle.
    task automatic xfer(input logic we, input logic [14:0] addr, input logic [15:0] sel,
                        input logic [127:0] wdat, output logic [127:0] rdat, output int ack_cyc);
        int k;
        s_cyc = 1'b1; s_stb = 1'b1; s_we = we; s_addr = addr; s_sel = sel; s_wdat = wdat;
        ack_cyc = -1;
        k = 0;
        while (ack_cyc < 0 && k < 300) begin
            @(posedge clock); #1;
            k++;
            if (s_ack_o) ack_cyc = k;
        end
        rdat  = s_dat_o;
        s_cyc = 1'b0; s_stb = 1'b0;
        @(posedge clock); #1;
        check("ack_one_cycle", 128'(s_ack_o), 128'(0));
    endtask

    task automatic check_beats(input string tag, input int base, input logic [14:0] addr0,
                               input logic we, input logic [15:0] sel, input logic [127:0] wdat);
        check({tag, "_count"}, 128'(log_n - base), 128'(4));
        for (int i = 0; i < 4; i++) begin
            check({tag, "_addr"}, 128'(log_addr[base+i]), 128'(addr0 + 15'(4*i)));
            check({tag, "_sel"},  128'(log_sel[base+i]),  128'(sel[i*4 +: 4]));
            check({tag, "_we"},   128'(log_we[base+i]),   128'(we));
            if (we) check({tag, "_wdat"}, 128'(log_dat[base+i]), 128'(wdat[i*32 +: 32]));
        end
    endtask

    localparam logic [127:0] BLK_10 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] BLK_20 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    localparam logic [127:0] PART_W = 128'h99999999_88888888_77777777_66666666;
    localparam logic [127:0] BLK_40 = 128'h55555555_55555555_77777777_55555555;

    initial begin
        logic [127:0] rd;
        int           lat;
        int           base;
        int           k;
        logic         seen_ack;

        reset = 1'b1; init_mem = 1'b1;
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_addr = 15'h0010; s_sel = 16'hFFFF; s_wdat = '0;
        @(posedge clock); #1;
        check("rst_p_cyc_1", 128'(p_cyc_o), 128'(0));
        @(posedge clock); #1;
        check("rst_p_cyc_2", 128'(p_cyc_o), 128'(0));
        check("rst_wide", {s_ack_o, s_dat_o}, 129'(0));
        check("rst_narrow", 128'({p_cyc_o, p_stb_o, p_we_o, p_sel_o, p_addr_o, p_dat_o}), 128'(0));
        s_cyc = 1'b0; s_stb = 1'b0;
        reset = 1'b0; init_mem = 1'b0;
        @(posedge clock); #1;
        check("idle_after_rst", 128'(p_cyc_o), 128'(0));

        base = log_n;
        xfer(1'b0, 15'h0010, 16'hFFFF, '0, rd, lat);
        check("rd10_lat", 128'(lat), 128'(28));
        check("rd10_data", rd, BLK_10);
        check_beats("rd10", base, 15'h0010, 1'b0, 16'hFFFF, '0);

        base = log_n;
        xfer(1'b1, 15'h0020, 16'hFFFF, BLK_20, rd, lat);
        check("wr20_lat", 128'(lat), 128'(28));
        check("wr20_echo", rd, BLK_20);
        check_beats("wr20", base, 15'h0020, 1'b1, 16'hFFFF, BLK_20);

        xfer(1'b0, 15'h0020, 16'hFFFF, '0, rd, lat);
        check("rd20_data", rd, BLK_20);

        base = log_n;
        xfer(1'b1, 15'h0040, 16'h00F0, PART_W, rd, lat);
        check_beats("wr40", base, 15'h0040, 1'b1, 16'h00F0, PART_W);
        base = log_n;
        xfer(1'b0, 15'h0040, 16'h00F0, '0, rd, lat);
        check("rd40_data", rd, BLK_40);
        check_beats("rd40", base, 15'h0040, 1'b0, 16'h00F0, '0);

        base = log_n;
        xfer(1'b0, 15'h0027, 16'hFFFF, '0, rd, lat);
        check("rd27_data", rd, BLK_20);
        check("rd27_addr0", 128'(log_addr[base]), 128'(15'h0020));

        n_lat = 1;
        xfer(1'b0, 15'h0010, 16'hFFFF, '0, rd, lat);
        check("n1_lat", 128'(lat), 128'(8));
        check("n1_data", rd, BLK_10);
        n_lat = 6;

        base = log_n;
        seen_ack = 1'b0;
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_addr = 15'h0010; s_sel = 16'hFFFF;
        k = 0;
        while (log_n < base + 2 && k < 100) begin
            @(posedge clock); #1;
            k++;
            if (s_ack_o) seen_ack = 1'b1;
        end
        check("mid_beat1_reached", 128'(log_n - base), 128'(2));
        reset = 1'b1; s_cyc = 1'b0; s_stb = 1'b0;
        @(posedge clock); #1;
        check("mid_p_cyc", 128'(p_cyc_o), 128'(0));
        if (s_ack_o) seen_ack = 1'b1;
        reset = 1'b0;
        @(posedge clock); #1;
        check("mid_p_cyc_after", 128'(p_cyc_o), 128'(0));
        if (s_ack_o) seen_ack = 1'b1;
        check("mid_no_ack", 128'(seen_ack), 128'(0));
        xfer(1'b0, 15'h0010, 16'hFFFF, '0, rd, lat);
        check("post_rst_lat", 128'(lat), 128'(28));
        check("post_rst_data", rd, BLK_10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
